// File: rtl/collision_pkg.sv
// collision_pkg: shared types and defaults for the background collision scheduler
//   state_t   scheduler FSM states
//   PIX_FREE  background pixel code meaning free space (shared with background/sprite logic)
package collision_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_REPORT} state_t;
    localparam int HEIGHT_DEF = 10;
    localparam int Y_MAX_DEF  = 239;
    localparam int PIX_W_DEF  = 3;
    localparam int PIX_FREE   = 0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above ptr (mod NUM_REQ)
//   req    in   NUM_REQ  request vector
//   ptr    in   IDX_W    highest-priority index
//   grant  out  NUM_REQ  one-hot grant
//   idx    out  IDX_W    binary index of grant
//   any    out  1        at least one request present
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = |req;
        // walk from farthest to nearest so the closest request to ptr wins
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr) + i) % NUM_REQ;
            if (req[j]) begin
                grant = NUM_REQ'(1) << j;
                idx   = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler: round-robin sharing of the background ROM port for vertical-strip collision scans
//   clock     in   1                system clock
//   resetn    in   1                asynchronous active-low reset
//   req       in   NUM_REQ          scan requests, held until done
//   req_x     in   NUM_REQ*COORD_W  client x coordinates
//   req_y     in   NUM_REQ*COORD_W  client top rows
//   bg_x      out  COORD_W          ROM column address
//   bg_y      out  COORD_W          ROM row address
//   bg_pixel  in   PIX_W            ROM data, ROM_LAT clocks after address
//   done      out  NUM_REQ          one-cycle scan-finished pulse
//   hit       out  NUM_REQ          last scan result per client
//   busy      out  1                scan in progress
module collision_scheduler
    import collision_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = 9,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int HEIGHT  = HEIGHT_DEF,
    parameter int Y_MAX   = Y_MAX_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    output logic [COORD_W-1:0]         bg_x,
    output logic [COORD_W-1:0]         bg_y,
    input  logic [PIX_W-1:0]           bg_pixel,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         hit,
    output logic                       busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int K_W   = $clog2(HEIGHT + 2);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d, g_q, g_d, idx;
    logic [COORD_W-1:0]   x0_q, x0_d, y0_q, y0_d;
    logic [K_W-1:0]       k_q, k_d;
    logic                 acc_q, acc_d, any, issue, off;
    logic [ROM_LAT-1:0]   vld_q, vld_d;
    logic [NUM_REQ-1:0]   done_q, done_d, hit_q, hit_d, grant;
    logic [COORD_W:0]     row;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    // one extra bit keeps the carry so wrapped rows are seen as off-screen
    assign row   = {1'b0, y0_q} + (COORD_W+1)'(k_q);
    assign off   = row > (COORD_W+1)'(Y_MAX);
    assign issue = state_q == S_ISSUE;
    assign bg_x  = x0_q;
    assign bg_y  = row[COORD_W-1:0];
    assign done  = done_q;
    assign hit   = hit_q;
    assign busy  = state_q != S_IDLE;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        k_d     = k_q;
        done_d  = '0;
        hit_d   = hit_q;
        // valid bit travels with each issued address until its pixel returns
        vld_d   = ROM_LAT'({vld_q, issue});
        acc_d   = acc_q | (issue & off) | (vld_q[ROM_LAT-1] & (bg_pixel != PIX_W'(PIX_FREE)));
        unique case (state_q)
            S_IDLE: if (any) begin
                state_d = S_ISSUE;
                g_d     = idx;
                k_d     = '0;
                acc_d   = 1'b0;
                for (int i = 0; i < NUM_REQ; i++)
                    if (grant[i]) begin
                        x0_d = req_x[i*COORD_W +: COORD_W];
                        y0_d = req_y[i*COORD_W +: COORD_W];
                    end
            end
            S_ISSUE: if (k_q == K_W'(HEIGHT)) state_d = S_DRAIN;
                     else k_d = k_q + K_W'(1);
            // leave once the last outstanding pixel is being sampled
            S_DRAIN: if (vld_d == '0) state_d = S_REPORT;
            S_REPORT: begin
                state_d     = S_IDLE;
                done_d[g_q] = 1'b1;
                hit_d[g_q]  = acc_q;
                ptr_d       = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            k_q     <= '0;
            acc_q   <= 1'b0;
            vld_q   <= '0;
            done_q  <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
        end
    end
endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: randomized scan rounds against a strip-level collision model
module tb_collision_scheduler;
    localparam int NUM_REQ = 4, COORD_W = 9, PIX_W = 3, HEIGHT = 10, Y_MAX = 239, ROM_LAT = 1;
    localparam int LAT = HEIGHT + ROM_LAT + 3;
    localparam int SPAN = 1 << COORD_W;

    logic clock = 1'b0, resetn = 1'b0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ*COORD_W-1:0] req_x = '0, req_y = '0;
    logic [COORD_W-1:0] bg_x, bg_y;
    logic [PIX_W-1:0] bg_pixel;
    logic [NUM_REQ-1:0] done, hit;
    logic busy;

    int n_vec = 0, n_miss = 0;
    int ptr_m = 0;
    logic [NUM_REQ-1:0] hit_m = '0;
    logic [PIX_W-1:0] rom [int];
    logic [PIX_W-1:0] pipe [ROM_LAT];

    always #5 clock = ~clock;

    collision_scheduler #(.NUM_REQ(NUM_REQ), .COORD_W(COORD_W), .PIX_W(PIX_W),
                          .HEIGHT(HEIGHT), .Y_MAX(Y_MAX), .ROM_LAT(ROM_LAT)) dut (
        .clock(clock), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
        .bg_x(bg_x), .bg_y(bg_y), .bg_pixel(bg_pixel), .done(done), .hit(hit), .busy(busy)
    );

    function automatic logic [PIX_W-1:0] rom_rd(int x, int y);
        return rom.exists(x * SPAN + y) ? rom[x * SPAN + y] : '0;
    endfunction

    always @(posedge clock) begin
        pipe[0] <= rom_rd(int'(bg_x), int'(bg_y));
        for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bg_pixel = pipe[ROM_LAT-1];

    function automatic logic strip_hit(int x, int y);
        for (int k = 0; k <= HEIGHT; k++) begin
            if (y + k > Y_MAX) return 1'b1;
            if (rom_rd(x, (y + k) % SPAN) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_xy(input int i, input int x, input int y);
        req_x[i*COORD_W +: COORD_W] = COORD_W'(x);
        req_y[i*COORD_W +: COORD_W] = COORD_W'(y);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_done"}, done, 0);
        check({tag, "_hit"}, hit, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_bgx"}, bg_x, 0);
        check({tag, "_bgy"}, bg_y, 0);
    endtask

    task automatic run_round(input logic [NUM_REQ-1:0] mask, input bit wiggle);
        logic [NUM_REQ-1:0] pend;
        int g, gx, gy;
        logic eh;
        req  = mask;
        pend = mask;
        while (pend != 0) begin
            g = -1;
            for (int i = 0; i < NUM_REQ; i++)
                if (g < 0 && pend[(ptr_m + i) % NUM_REQ]) g = (ptr_m + i) % NUM_REQ;
            gx = int'(req_x[g*COORD_W +: COORD_W]);
            gy = int'(req_y[g*COORD_W +: COORD_W]);
            eh = strip_hit(gx, gy);
            for (int t = 1; t <= LAT; t++) begin
                @(negedge clock);
                if (t < LAT) begin
                    check("done_early", done, 0);
                    check("busy", busy, 1);
                end
                if (t <= HEIGHT + 1) begin
                    check("bg_x", bg_x, gx);
                    check("bg_y", bg_y, (gy + t - 1) % SPAN);
                end
                if (wiggle && t == 6) begin
                    set_xy(g, $urandom_range(0, SPAN - 1), $urandom_range(0, SPAN - 1));
                    if ($urandom_range(0, 1) == 1) req[g] = 1'b0;
                end
            end
            hit_m[g] = eh;
            check("done", done, 32'(1) << g);
            check("hit", hit, hit_m);
            check("busy_gap", busy, 0);
            pend[g] = 1'b0;
            req[g]  = 1'b0;
            ptr_m   = (g + 1) % NUM_REQ;
        end
    endtask

    function automatic int rand_y();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, SPAN - 1);
            1: return $urandom_range(Y_MAX - 14, Y_MAX + 6);
            2: return $urandom_range(SPAN - 12, SPAN - 1);
            default: return $urandom_range(0, 200);
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clock);
        check_quiet("reset");
        resetn = 1'b1;
        @(negedge clock);

        set_xy(0, 20, 50);
        run_round(4'b0001, 1'b0);
        rom[20 * SPAN + 60] = 3'd5;
        run_round(4'b0001, 1'b0);
        rom.delete();
        rom[20 * SPAN + 61] = 3'd1;
        rom[21 * SPAN + 55] = 3'd2;
        run_round(4'b0001, 1'b0);
        rom.delete();
        set_xy(0, 20, 235);
        run_round(4'b0001, 1'b0);
        set_xy(0, 20, 229);
        run_round(4'b0001, 1'b0);
        set_xy(0, 20, 505);
        run_round(4'b0001, 1'b0);

        for (int i = 0; i < NUM_REQ; i++) set_xy(i, 40 * i + 7, 30 * i + 3);
        rom[47 * SPAN + 40] = 3'd7;
        run_round(4'b1111, 1'b0);
        run_round(4'b0100, 1'b0);

        req = 4'b1000;
        repeat (6) @(negedge clock);
        check("pre_reset_bgy", bg_y, 30 * 3 + 3 + 5);
        resetn = 1'b0;
        #1;
        check_quiet("async_reset");
        @(negedge clock);
        resetn = 1'b1;
        req    = '0;
        ptr_m  = 0;
        hit_m  = '0;
        @(negedge clock);
        check_quiet("post_reset");
        run_round(4'b1100, 1'b0);

        for (int r = 0; r < 150; r++) begin
            rom.delete();
            for (int i = 0; i < NUM_REQ; i++) begin
                int x, y;
                x = $urandom_range(0, SPAN - 1);
                y = rand_y();
                set_xy(i, x, y);
                repeat ($urandom_range(0, 2))
                    rom[((x + $urandom_range(0, 2) + SPAN - 1) % SPAN) * SPAN +
                        (y + $urandom_range(0, 12) + SPAN - 1) % SPAN] = PIX_W'($urandom_range(1, 7));
            end
            run_round(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clock);
                check("idle_busy", busy, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
